spi_reg_bank: RTL
=================

# spi_reg_bank

Parametrised SPI peripheral register bank: the successor to the fixed 5-register write-only SPI slave. Receives framed SPI transactions (CPOL selectable, CPHA=0) clocked by the external controller. Oversamples `sclk`/`ncs`/`copi` in the system clock domain and commits writes atomically into `NUM_REGS` registers of `DATA_W` bits. Optionally returns register contents on `cipo`. Sits between the chip pins and the PWM/output-enable logic.

## Interface
- `NUM_REGS`, 5, number of registers (1..2**ADDR_W)
- `ADDR_W`, 7, address field width
- `DATA_W`, 8, register/data field width
- `CPOL`, 0, idle sclk level; leading edge = rising when 0, falling when 1
- `SYNC_STAGES`, 2, synchroniser depth for sclk/ncs/copi (≥2)
- `clk  in  1  system clock (10 MHz nominal)`
- `rst  in  1  reset; asynchronous, active-high`
- `ncs  in  1  chip select, active low (asynchronous to clk)`
- `sclk  in  1  SPI clock from controller`
- `copi  in  1  controller-out peripheral-in`
- `cipo  out  1  peripheral-out controller-in`
- `cipo_oe  out  1  pad output enable for cipo`
- `reg_q  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W]`
- `wr_strobe  out  NUM_REGS  one-cycle pulse when reg i is written`
- `frame_err  out  1  one-cycle pulse on aborted/overlong frame`

## Operation
- Frame width FRAME_W = 1+ADDR_W+DATA_W, MSB first: bit[FRAME_W-1] = R/W (1=write), then address, then data.
- `copi` sampled on synchronised leading edge; `cipo` updated on synchronised trailing edge.
- FSM states: IDLE, SHIFT, COMMIT, DRAIN.
  - IDLE: bit count 0. Synchronised ncs falling edge → SHIFT; shift register cleared.
  - SHIFT: each leading edge shifts one bit in, count+1. Count reaches FRAME_W → COMMIT. ncs rises with count < FRAME_W → pulse frame_err, discard, → IDLE.
  - COMMIT (1 cycle): if write and address < NUM_REGS: load reg, pulse its wr_strobe. Reads and out-of-range addresses: no register change, no strobe, no error. → DRAIN.
  - DRAIN: wait for ncs high → IDLE. Any leading edge in DRAIN pulses frame_err once per edge; no data effect.
- Reset (any time, including mid-frame): state IDLE, count 0, shift regs 0, reg_q all 0, wr_strobe 0, frame_err 0, cipo 0, cipo_oe 0.
- Simultaneous ncs rise and final leading edge in the same clk cycle: edge taken first, frame completes and commits.
- Unwritten registers retain value; only addressed DATA_W slice changes.

## Timing
- Synchronised edge flag asserts SYNC_STAGES+1 clk after the pin edge.
- Final leading edge flag at cycle t: count = FRAME_W at t+1 (COMMIT); reg_q and wr_strobe valid at t+2.
- Frame abort: frame_err at synchronised ncs-rise flag +1 clk.
- Requirement on controller: sclk half-period ≥ SYNC_STAGES+3 clk cycles (≥5 clk at default, 1 MHz max at 10 MHz clk).
- cipo_oe: asserts 1 clk after synchronised ncs falling edge; deasserts 1 clk after synchronised ncs rise or reset.

## Configuration
- `SPI_READBACK_EN` defined: after the address field of a read frame (R/W=0) is complete (count = 1+ADDR_W), addressed register loaded into tx shift register by the next clk. Its MSB drives cipo from the following trailing edge, one bit per trailing edge. Out-of-range address returns all zeros. cipo_oe as in Timing.
- Undefined: cipo and cipo_oe constant 0; read frames parsed and discarded; no tx logic synthesised.

## Structure
- Package `spi_reg_pkg`: FSM state enum (IDLE/SHIFT/COMMIT/DRAIN), R/W bit encoding constants, named register addresses (EN_OUT_LO=0, EN_OUT_HI=1, EN_PWM_LO=2, EN_PWM_HI=3, PWM_DUTY=4).
- Sub-module `spi_pin_sync`: SYNC_STAGES-deep synchroniser plus rise/fall edge flags, instantiated for sclk and ncs; copi uses synchroniser only.

## Test plan
- Write 0x1_04_A5 (w, addr 4, data 0xA5), default params → reg 4 = 0xA5 at t+2, wr_strobe[4] one cycle, other regs 0.
- Write to addr 7 (≥NUM_REGS) → no reg change, no strobe, no frame_err.
- ncs raised after 10 of 16 bits → frame_err pulse, all regs unchanged; next full write to addr 0 = 0x3C succeeds.
- 17 sclk pulses in one frame writing addr 1 = 0xFF → reg 1 = 0xFF, one frame_err for the extra edge.
- Assert rst mid-frame after writing reg 2 = 0x55 → all outputs 0 immediately (async), frame discarded.
- With SPI_READBACK_EN, after reg 3 = 0x96, read addr 3 (CPOL=1 run too) → cipo bits 1,0,0,1,0,1,1,0 on the 8 data-phase edges, cipo_oe high only while ncs low.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank: FSM states, R/W
// encoding and the named register map used by the PWM/output-enable logic.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int unsigned EN_OUT_LO = 0;
  localparam int unsigned EN_OUT_HI = 1;
  localparam int unsigned EN_PWM_LO = 2;
  localparam int unsigned EN_PWM_HI = 3;
  localparam int unsigned PWM_DUTY  = 4;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the chip pads (master side) and the register bank.
interface spi_reg_bank_if;

  logic ncs;
  logic sclk;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output ncs, output sclk, output copi, input cipo, input cipo_oe);
  modport slave  (input ncs, input sclk, input copi, output cipo, output cipo_oe);

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for an asynchronous pin, exposing the synchronised
// level and a one-cycle toggle flag; rise/fall is level & toggle / ~level & toggle.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic toggle_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, pin});
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign toggle_c = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI (CPHA=0) peripheral register bank with atomic frame commit.
// Optional register readback on cipo when SPI_READBACK_EN is defined.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W   = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W     = $clog2(FRAME_W + 1);
  localparam logic        SCLK_IDLE = (CPOL != 0);

  logic sclk_lvl, sclk_tgl, ncs_lvl, ncs_tgl;
  logic lead, ncs_fall, ncs_rise, copi_s;
  logic [SYNC_STAGES-1:0] copi_sync_q;

  state_t                     state_q, state_n;
  logic [CNT_W-1:0]           cnt_q, cnt_n;
  logic [FRAME_W-1:0]         shift_q, shift_n;
  logic [NUM_REGS*DATA_W-1:0] reg_n;
  logic [NUM_REGS-1:0]        strobe_n;
  logic                       err_n;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .rst(rst), .pin(spi.sclk), .level(sclk_lvl), .toggle_c(sclk_tgl)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk(clk), .rst(rst), .pin(spi.ncs), .level(ncs_lvl), .toggle_c(ncs_tgl)
  );

  // Leading edge moves sclk away from its idle level.
  assign lead     = sclk_tgl & (sclk_lvl != SCLK_IDLE);
  assign ncs_fall = ncs_tgl & ~ncs_lvl;
  assign ncs_rise = ncs_tgl & ncs_lvl;
  assign copi_s   = copi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      copi_sync_q <= '0;
      reg_q       <= '0;
      wr_strobe   <= '0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      shift_q     <= shift_n;
      copi_sync_q <= SYNC_STAGES'({copi_sync_q, spi.copi});
      reg_q       <= reg_n;
      wr_strobe   <= strobe_n;
      frame_err   <= err_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shift_n  = shift_q;
    reg_n    = reg_q;
    strobe_n = '0;
    err_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (ncs_fall) begin
          state_n = SHIFT;
          shift_n = '0;
        end
      end
      SHIFT: begin
        // A final edge coinciding with ncs rise still completes the frame.
        if (lead) begin
          shift_n = {shift_q[FRAME_W-2:0], copi_s};
          cnt_n   = cnt_q + CNT_W'(1);
        end
        if (lead && cnt_q == CNT_W'(FRAME_W - 1)) begin
          state_n = COMMIT;
        end else if (ncs_rise) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      COMMIT: begin
        state_n = DRAIN;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (shift_q[FRAME_W-1] == RW_WRITE && shift_q[DATA_W +: ADDR_W] == ADDR_W'(i)) begin
            reg_n[i*DATA_W +: DATA_W] = shift_q[DATA_W-1:0];
            strobe_n[i]               = 1'b1;
          end
        end
      end
      DRAIN: begin
        err_n = lead;
        if (ncs_lvl) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SPI_READBACK_EN
  logic              trail;
  logic [DATA_W-1:0] tx_q, tx_n, rd_word;
  logic              cipo_q, cipo_n, oe_q, oe_n;

  assign trail = sclk_tgl & (sclk_lvl == SCLK_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q   <= '0;
      cipo_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      tx_q   <= tx_n;
      cipo_q <= cipo_n;
      oe_q   <= oe_n;
    end
  end

  // Read word is latched as the last address bit is shifted in.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (shift_n[ADDR_W-1:0] == ADDR_W'(i)) rd_word = reg_q[i*DATA_W +: DATA_W];
    end
    tx_n   = tx_q;
    cipo_n = cipo_q;
    oe_n   = ncs_fall ? 1'b1 : (ncs_rise ? 1'b0 : oe_q);
    if (state_q == IDLE) begin
      tx_n   = '0;
      cipo_n = 1'b0;
    end else begin
      if (trail) begin
        cipo_n = tx_q[DATA_W-1];
        tx_n   = tx_q << 1;
      end
      if (state_q == SHIFT && lead && cnt_q == CNT_W'(ADDR_W) && shift_n[ADDR_W] == RW_READ) begin
        tx_n = rd_word;
      end
    end
  end

  assign spi.cipo    = cipo_q;
  assign spi.cipo_oe = oe_q;
`else
  assign spi.cipo    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

endmodule
